// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a fixed-length burst from a FIFO onto a valid/ready stream
//
// Optional feature macro: FIFO_READER_TIMEOUT_EN (starvation timeout, reported on timeout_err)
//
// Ports:
//   clk, rst                          clock; asynchronous active-low reset
//   start, burst_len                  burst request (sampled only in IDLE) and word count
//   busy, done, timeout_err           burst status; done is a one-cycle pulse
//   fifo_empty, fifo_pop, fifo_rdata  FIFO read side; rdata is valid the cycle after the pop edge
//   m_data, m_valid, m_ready, m_last  output stream; m_last marks the final word of the burst
//   words_sent                        stream handshakes in the current/last burst
module fifo_burst_reader #(
   parameter int DATA_SIZE      = 8,
   parameter int MAX_BURST      = 16,
   parameter int LEN_W          = $clog2(MAX_BURST + 1),
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     burst_len,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err,
   input  logic                 fifo_empty,
   output logic                 fifo_pop,
   input  logic [DATA_SIZE-1:0] fifo_rdata,
   output logic [DATA_SIZE-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [LEN_W-1:0]     words_sent
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

   state_t               state, state_nxt;
   logic [LEN_W-1:0]     len;
   logic [LEN_W-1:0]     issued;
   logic [LEN_W-1:0]     len_sel;
   logic                 inflight;
   logic [DATA_SIZE-1:0] buf_mem [2];
   logic                 rd_ptr, wr_ptr;
   logic [1:0]           buf_count;
   logic [1:0]           occ;
   logic                 hs;
   logic                 accept;
   logic                 to_hit;
   logic                 to_err;

   assign len_sel = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
   assign accept  = (state == S_IDLE) && start;
   assign hs      = (buf_count != 2'd0) && m_ready;

`ifdef FIFO_READER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt;
   logic          starving;

   assign starving = (state == S_RUN) && (issued < len) && fifo_empty;
   assign to_hit   = starving && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= '0;
         to_err <= 1'b0;
      end else if (accept) begin
         to_cnt <= '0;
         to_err <= 1'b0;
      end else if (fifo_pop) begin
         to_cnt <= '0;
      end else if (to_hit) begin
         to_cnt <= '0;
         to_err <= 1'b1;
      end else if (starving) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end
`else
   // No counter in this build: never true, the comparison only keeps the limit referenced.
   assign to_hit = (TIMEOUT_CYCLES < 0);
   assign to_err = 1'b0;
`endif

   assign timeout_err = to_err;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (len_sel == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (to_hit)
               state_nxt = S_DRAIN;
            else if (fifo_pop && (issued + LEN_W'(1) == len))
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave on the cycle of the final handshake so done follows it directly.
            if (to_err) begin
               if ((buf_count == {1'b0, hs}) && !inflight) state_nxt = S_DONE;
            end else if (words_sent + LEN_W'(hs) == len) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy    = (state != S_IDLE);
      done    = (state == S_DONE);
      m_valid = (buf_count != 2'd0);
      m_data  = buf_mem[rd_ptr];
      m_last  = m_valid && (words_sent == len - LEN_W'(1)) && !to_err;
      // Credit = buffered + in-flight words, less the one leaving this cycle; counting the
      // departing word keeps one pop per cycle when the sink is ready, and a stalled sink
      // still caps occupancy at two.
      occ      = buf_count + {1'b0, inflight} - {1'b0, hs};
      fifo_pop = (state == S_RUN) && !fifo_empty && (issued < len) && (occ < 2'd2);
   end

   // Datapath: burst counters and the 2-entry output buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len        <= '0;
         issued     <= '0;
         words_sent <= '0;
         inflight   <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         buf_count  <= 2'd0;
      end else begin
         inflight <= fifo_pop;
         if (inflight) begin
            buf_mem[wr_ptr] <= fifo_rdata;
            wr_ptr          <= ~wr_ptr;
         end
         if (hs) rd_ptr <= ~rd_ptr;
         buf_count <= buf_count + {1'b0, inflight} - {1'b0, hs};
         if (accept) begin
            len        <= len_sel;
            issued     <= '0;
            words_sent <= '0;
         end else begin
            if (fifo_pop) issued <= issued + LEN_W'(1);
            if (hs)       words_sent <= words_sent + LEN_W'(1);
         end
      end
   end

endmodule
